// File: rtl/avmm_block_mover.sv
// Avalon-MM block mover: copies or fills a run of words through a single master port.
// Define AVMM_BLOCK_MOVER_CHECKSUM_EN to sum every accepted write word into checksum.
module avmm_block_mover #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_mode,
  input  logic [ADDR_W-1:0]   cmd_src,
  input  logic [ADDR_W-1:0]   cmd_dst,
  input  logic [ADDR_W:0]     cmd_len,
  input  logic [DATA_W-1:0]   cmd_fill,
  output logic                busy,
  output logic                done,
  output logic [DATA_W-1:0]   checksum,
  input  logic                abort,
  output logic [ADDR_W-1:0]   address,
  output logic                chipselect,
  output logic                read,
  output logic                write,
  output logic [DATA_W/8-1:0] byteenable,
  output logic [DATA_W-1:0]   writedata,
  input  logic [DATA_W-1:0]   readdata,
  input  logic                waitrequest
);

  typedef enum logic [2:0] {IDLE, RD, RDATA, WR, FIN} state_t;

  state_t              state_reg;
  logic [ADDR_W:0]     idx_reg;
  logic [ADDR_W:0]     len_reg;
  logic [ADDR_W-1:0]   src_reg;
  logic [ADDR_W-1:0]   dst_reg;
  logic [ADDR_W-1:0]   address_reg;
  logic [DATA_W-1:0]   writedata_reg;
  logic                mode_reg;
  logic                abort_pend_reg;
  logic [ADDR_W:0]     idx_inc;

  assign idx_inc = idx_reg + 1'b1;

  // Bus strobes decode straight from the state register, so they are glitch-free and stable.
  assign cmd_ready  = (state_reg == IDLE);
  assign busy       = (state_reg != IDLE);
  assign read       = (state_reg == RD);
  assign write      = (state_reg == WR);
  assign chipselect = read | write;
  assign done       = (state_reg == FIN);
  assign byteenable = '1;
  assign address    = address_reg;
  assign writedata  = writedata_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      len_reg        <= '0;
      src_reg        <= '0;
      dst_reg        <= '0;
      address_reg    <= '0;
      writedata_reg  <= '0;
      mode_reg       <= 1'b0;
      abort_pend_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          abort_pend_reg <= 1'b0;
          if (cmd_valid) begin
            idx_reg  <= '0;
            len_reg  <= cmd_len;
            src_reg  <= cmd_src;
            dst_reg  <= cmd_dst;
            mode_reg <= cmd_mode;
            if (cmd_len == '0) begin
              state_reg <= FIN;
            end else if (cmd_mode) begin
              state_reg     <= WR;
              address_reg   <= cmd_dst;
              writedata_reg <= cmd_fill;
            end else begin
              state_reg   <= RD;
              address_reg <= cmd_src;
            end
          end
        end
        RD: begin
          if (abort) abort_pend_reg <= 1'b1;
          if (!waitrequest) state_reg <= RDATA;
        end
        RDATA: begin
          // Abort during a read still lets the read finish, but suppresses its write.
          writedata_reg <= readdata;
          address_reg   <= dst_reg + idx_reg[ADDR_W-1:0];
          if (abort || abort_pend_reg) state_reg <= FIN;
          else                         state_reg <= WR;
        end
        WR: begin
          if (abort) abort_pend_reg <= 1'b1;
          if (!waitrequest) begin
            idx_reg <= idx_inc;
            if (abort || abort_pend_reg || idx_inc == len_reg) begin
              state_reg <= FIN;
            end else if (mode_reg) begin
              address_reg <= dst_reg + idx_inc[ADDR_W-1:0];
            end else begin
              address_reg <= src_reg + idx_inc[ADDR_W-1:0];
              state_reg   <= RD;
            end
          end
        end
        FIN:     state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef AVMM_BLOCK_MOVER_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      checksum_reg <= '0;
    end else if (state_reg == IDLE && cmd_valid) begin
      checksum_reg <= '0;
    end else if (state_reg == WR && !waitrequest) begin
      checksum_reg <= checksum_reg + writedata_reg;
    end
  end

  assign checksum = checksum_reg;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_avmm_block_mover.sv
// Randomized bench for avmm_block_mover: slave memory model, transaction-level reference
// model and a per-cycle compare process.
module tb_avmm_block_mover;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready, cmd_mode;
  logic [11:0] cmd_src, cmd_dst;
  logic [12:0] cmd_len;
  logic [31:0] cmd_fill;
  logic        busy, done;
  logic [31:0] checksum;
  logic        abort;
  logic [11:0] address;
  logic        chipselect, read, write;
  logic [3:0]  byteenable;
  logic [31:0] writedata, readdata;
  logic        waitrequest;

  always #5 clk = ~clk;

  avmm_block_mover dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_fill(cmd_fill),
    .busy(busy), .done(done), .checksum(checksum), .abort(abort),
    .address(address), .chipselect(chipselect), .read(read), .write(write),
    .byteenable(byteenable), .writedata(writedata), .readdata(readdata),
    .waitrequest(waitrequest)
  );

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [31:0] data;
  } op_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] mem [4096];
  logic [31:0] ref_mem [4096];
  op_t         exp_q[$];
  logic [31:0] exp_cs = '0;
  bit          outstanding = 0;
  int          wmode = 0;
  int          abort_at = -1;
  int          ops_seen = 0;
  int          wr_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic give_up(input string what);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired before the DUT event", what);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // Reference: ascending word-by-word transfer, truncated after op index abort_j.
  task automatic model_cmd(input bit mode, input logic [11:0] src, input logic [11:0] dst,
                           input int len, input logic [31:0] fill, input int abort_j);
    op_t         op;
    logic [31:0] v, sum;
    int          n;
    bit          stop;
    sum = '0; n = 0; stop = 0;
    for (int i = 0; i < len && !stop; i++) begin
      if (!mode) begin
        op.wr = 0; op.addr = src + 12'(i); op.data = '0;
        exp_q.push_back(op);
        if (n == abort_j) stop = 1;
        n++;
        v = ref_mem[op.addr];
      end else begin
        v = fill;
      end
      if (!stop) begin
        op.wr = 1; op.addr = dst + 12'(i); op.data = v;
        exp_q.push_back(op);
        ref_mem[op.addr] = v;
        sum = sum + v;
        if (n == abort_j) stop = 1;
        n++;
      end
    end
`ifdef AVMM_BLOCK_MOVER_CHECKSUM_EN
    exp_cs = sum;
`else
    exp_cs = '0;
`endif
  endtask

  task automatic run_cmd(input bit mode, input logic [11:0] src, input logic [11:0] dst,
                         input int len, input logic [31:0] fill, input int abort_j,
                         input int wm, output int lat);
    int n, acc;
    @(negedge clk); #2;
    n = 0;
    while (!cmd_ready) begin
      @(negedge clk); #2;
      n++;
      if (n > 1000) give_up("ready_wait");
    end
    wmode = wm; abort_at = abort_j; ops_seen = 0;
    model_cmd(mode, src, dst, len, fill, abort_j);
    outstanding = 1;
    cmd_valid = 1; cmd_mode = mode; cmd_src = src; cmd_dst = dst;
    cmd_len = 13'(len); cmd_fill = fill;
    @(posedge clk); #1;
    acc = cyc;
    cmd_valid = 0;
    lat = -1; n = 0;
    while (lat < 0) begin
      @(negedge clk); #2;
      if (done) begin
        lat = cyc - acc + 1;
        cmd_valid = 0;
      end else begin
        // Junk commands while busy must be ignored.
        cmd_valid = 1'($urandom); cmd_mode = 1'($urandom);
        cmd_src = 12'($urandom); cmd_dst = 12'($urandom);
        cmd_len = 13'($urandom); cmd_fill = $urandom;
      end
      n++;
      if (n > 5000) give_up("done_wait");
    end
    abort_at = -1;
    $display("cmd mode=%0d src=0x%03h dst=0x%03h len=%0d abort_op=%0d wmode=%0d latency=%0d",
             mode, src, dst, len, abort_j, wm, lat);
  endtask

  // Avalon slave: memory with fixed read latency 1, waitrequest policy, abort injection.
  initial begin
    int          wcnt;
    bit          rd_pend;
    logic [11:0] rd_addr;
    wcnt = 0; rd_pend = 0; rd_addr = '0;
    waitrequest = 0; readdata = '0; abort = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        rd_pend = 0; wcnt = 0; waitrequest = 0; abort = 0;
      end else begin
        readdata = rd_pend ? mem[rd_addr] : $urandom;
        rd_pend = 0;
        case (wmode)
          0: waitrequest = 0;
          1: waitrequest = (read || write) && ($urandom % 3 == 0);
          default: begin
            if ((read || write) && wcnt < 2) begin
              waitrequest = 1; wcnt++;
            end else begin
              waitrequest = 0; wcnt = 0;
            end
          end
        endcase
        abort = 0;
        if ((read || write) && abort_at >= 0 && ops_seen == abort_at) begin
          abort = 1; abort_at = -1;
        end
        if ((read || write) && !waitrequest) begin
          if (write) begin
            mem[address] = writedata; wr_count++;
          end else begin
            rd_pend = 1; rd_addr = address;
          end
          ops_seen++;
        end
      end
    end
  end

  // Compare process: every cycle, bus rules plus ordered transfers against the model queue.
  initial begin
    bit          p_wait;
    logic        p_rd, p_wr;
    logic [11:0] p_addr;
    logic [31:0] p_wd;
    p_wait = 0; p_rd = 0; p_wr = 0; p_addr = '0; p_wd = '0;
    forever begin
      @(negedge clk); #1;
      if (!reset_n) begin
        chk("rst_read", 32'(read), 0);
        chk("rst_write", 32'(write), 0);
        chk("rst_cs", 32'(chipselect), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_addr", 32'(address), 0);
        chk("rst_wdata", writedata, 0);
        chk("rst_cksum", checksum, 0);
        chk("rst_be", 32'(byteenable), 32'hF);
        chk("rst_ready", 32'(cmd_ready), 1);
        exp_q.delete();
        outstanding = 0;
        p_wait = 0;
      end else begin
        chk("cs_is_rd_or_wr", 32'(chipselect), 32'(read | write));
        chk("rd_wr_exclusive", 32'(read & write), 0);
        if (chipselect) chk("byteenable", 32'(byteenable), 32'hF);
        chk("ready_vs_busy", 32'(cmd_ready), 32'(!busy));
        if (p_wait) begin
          chk("hold_read", 32'(read), 32'(p_rd));
          chk("hold_write", 32'(write), 32'(p_wr));
          chk("hold_addr", 32'(address), 32'(p_addr));
          chk("hold_wdata", writedata, p_wd);
        end
        if ((read || write) && !waitrequest) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_op: got wr=%0d addr=0x%03h, expected no transfer",
                     write, address);
          end else begin
            op_t e;
            e = exp_q.pop_front();
            chk("op_kind", 32'(write), 32'(e.wr));
            chk("op_addr", 32'(address), 32'(e.addr));
            if (e.wr) chk("op_data", writedata, e.data);
          end
        end
        if (done) begin
          chk("done_expected", 32'(outstanding), 1);
          chk("done_ops_left", 32'(exp_q.size()), 0);
          chk("checksum", checksum, exp_cs);
          outstanding = 0;
        end
        p_wait = (read || write) && waitrequest;
        p_rd = read; p_wr = write; p_addr = address; p_wd = writedata;
      end
    end
  end

  initial begin
    int          lat, w0;
    logic [31:0] keep, v;
    reset_n = 0; cmd_valid = 0; cmd_mode = 0; cmd_src = '0; cmd_dst = '0;
    cmd_len = '0; cmd_fill = '0;
    for (int i = 0; i < 4096; i++) begin
      v = $urandom; mem[i] = v; ref_mem[i] = v;
    end
    repeat (3) @(negedge clk);
    #3 reset_n = 1;

    // Fill: 4 writes back to back, done in cycle 5.
    run_cmd(1, 12'h000, 12'h010, 4, 32'hA5A5A5A5, -1, 0, lat);
    chk("fill_latency", 32'(lat), 5);
    for (int i = 0; i < 4; i++) chk("fill_mem", mem[12'h010 + 12'(i)], 32'hA5A5A5A5);
`ifdef AVMM_BLOCK_MOVER_CHECKSUM_EN
    chk("fill_cksum_lit", checksum, 32'h96969694);
`else
    chk("fill_cksum_lit", checksum, 32'h0);
`endif

    // Copy 1,2,3: 3 cycles per word plus done.
    for (int i = 0; i < 3; i++) begin
      mem[12'h100 + 12'(i)] = 32'(i + 1); ref_mem[12'h100 + 12'(i)] = 32'(i + 1);
    end
    run_cmd(0, 12'h100, 12'h200, 3, 32'h0, -1, 0, lat);
    chk("copy_latency", 32'(lat), 10);
    for (int i = 0; i < 3; i++) chk("copy_mem", mem[12'h200 + 12'(i)], 32'(i + 1));

    // Copy with two wait cycles on every transfer: 7 cycles per word plus done.
    run_cmd(0, 12'h100, 12'h240, 3, 32'h0, -1, 2, lat);
    chk("wait_latency", 32'(lat), 22);
    for (int i = 0; i < 3; i++) chk("wait_mem", mem[12'h240 + 12'(i)], 32'(i + 1));

    // Address wrap and zero length.
    run_cmd(1, 12'h000, 12'hFFF, 2, 32'h12345678, -1, 0, lat);
    chk("wrap_latency", 32'(lat), 3);
    chk("wrap_mem_fff", mem[12'hFFF], 32'h12345678);
    chk("wrap_mem_000", mem[12'h000], 32'h12345678);
    w0 = wr_count;
    run_cmd(1, 12'h000, 12'h050, 0, 32'hDEADBEEF, -1, 0, lat);
    chk("len0_latency", 32'(lat), 1);
    chk("len0_writes", 32'(wr_count - w0), 0);

    // Abort during the read of word 1 of an 8-word copy.
    keep = mem[12'h501];
    w0 = wr_count;
    run_cmd(0, 12'h400, 12'h500, 8, 32'h0, 2, 0, lat);
    chk("abort_latency", 32'(lat), 6);
    chk("abort_writes", 32'(wr_count - w0), 1);
    chk("abort_word0", mem[12'h500], mem[12'h400]);
    chk("abort_word1_kept", mem[12'h501], keep);

    for (int t = 0; t < 40; t++) begin
      bit          m;
      int          len, aj, wm;
      logic [11:0] s, d;
      logic [31:0] f;
      m   = 1'($urandom);
      len = ($urandom % 8 == 0) ? 0 : 1 + int'($urandom % 12);
      s   = 12'($urandom);
      d   = ($urandom % 4 == 0) ? 12'hFF8 + 12'($urandom % 8) : 12'($urandom);
      f   = $urandom;
      aj  = ($urandom % 4 == 0 && len > 0) ? int'($urandom % 32'(2 * len)) : -1;
      wm  = int'($urandom % 3);
      run_cmd(m, s, d, len, f, aj, wm, lat);
      if (wm == 0 && aj < 0)
        chk("rand_latency", 32'(lat), 32'(len == 0 ? 1 : (m ? len + 1 : 3 * len + 1)));
    end

    // Reset in the middle of an 8-word fill.
    @(negedge clk); #2;
    wmode = 0;
    for (int i = 0; i < 8; i++) begin
      op_t op;
      op.wr = 1; op.addr = 12'h700 + 12'(i); op.data = 32'hCAFEF00D;
      exp_q.push_back(op);
    end
    outstanding = 1;
    cmd_valid = 1; cmd_mode = 1; cmd_dst = 12'h700; cmd_len = 13'd8; cmd_fill = 32'hCAFEF00D;
    @(posedge clk); #1 cmd_valid = 0;
    repeat (3) @(posedge clk);
    #2 reset_n = 0;
    #1;
    chk("async_rst_write", 32'(write), 0);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_addr", 32'(address), 0);
    chk("async_rst_ready", 32'(cmd_ready), 1);
    repeat (2) @(negedge clk);
    #3 reset_n = 1;
    @(negedge clk); #2;
    chk("post_rst_ready", 32'(cmd_ready), 1);
    chk("post_rst_no_done", 32'(done), 0);
    $display("reset during fill: released, ready=%0d", cmd_ready);
    run_cmd(1, 12'h000, 12'h600, 3, 32'h0BADCAFE, -1, 0, lat);
    chk("post_rst_latency", 32'(lat), 4);
    for (int i = 0; i < 3; i++) chk("post_rst_mem", mem[12'h600 + 12'(i)], 32'h0BADCAFE);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
